// File: rtl/branch_pkg.sv
// Shared constants and types for branch resolution and the BHT.
package branch_pkg;

    // Branch condition selects (funct3 field of opcode 1100011)
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Control-transfer opcodes
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef logic [1:0] bht_ctr_t;

    // Weakly not-taken
    localparam bht_ctr_t BHT_RESET = 2'b01;

    // Saturating 2-bit counter step
    function automatic bht_ctr_t bht_next(input bht_ctr_t cur, input logic taken);
        bht_ctr_t nxt;
        nxt = cur;
        if (taken) begin
            if (cur != 2'b11) nxt = cur + 2'b01;
        end else begin
            if (cur != 2'b00) nxt = cur - 2'b01;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bht_2bit.sv
// 2-bit saturating branch history table: combinational read, clocked update.
module bht_2bit
    import branch_pkg::*;
#(
    parameter int unsigned ENTRIES = 64,
    parameter int unsigned XLEN    = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] rd_pc,
    output bht_ctr_t        rd_ctr,
    input  logic            upd_en,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_taken
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);

    bht_ctr_t         tbl [ENTRIES];
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] upd_idx;
    logic             unused_pc_bits;

    assign rd_idx  = rd_pc[IDX_W+1:2];
    assign upd_idx = upd_pc[IDX_W+1:2];
    assign unused_pc_bits = ^{rd_pc[XLEN-1:IDX_W+2], rd_pc[1:0],
                              upd_pc[XLEN-1:IDX_W+2], upd_pc[1:0]};

    // Read returns the stored value, so a same-cycle update is not visible yet
    assign rd_ctr = tbl[rd_idx];

    // Table initialisation on reset and saturating update on a resolved branch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                tbl[i] <= BHT_RESET;
            end
        end else if (upd_en) begin
            tbl[upd_idx] <= bht_next(tbl[upd_idx], upd_taken);
        end
    end

endmodule

// File: rtl/branch_resolve_bht.sv
// Branch resolution in EX with registered redirect, BHT and mispredict counter.
module branch_resolve_bht
    import branch_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned BHT_ENTRIES = 64,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [XLEN-1:0]  if_pc,
    output logic             if_pred_taken,
    input  logic             ex_valid,
    input  logic             ex_stall,
    input  logic             ex_branch,
    input  logic             ex_jump,
    input  logic [2:0]       ex_funct3,
    input  logic [XLEN-1:0]  ex_rs1,
    input  logic [XLEN-1:0]  ex_rs2,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic [XLEN-1:0]  ex_target,
    input  logic             ex_pred_taken,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             resolved_taken,
    output logic [CNT_W-1:0] mispredict_cnt
);

    bht_ctr_t rd_ctr;
    logic     unused_ctr_lsb;
    logic     accept;
    logic     cond_taken;
    logic     f3_valid;
    logic     taken;
    logic     mispredict;
    logic     bht_upd;

    bht_2bit #(
        .ENTRIES (BHT_ENTRIES),
        .XLEN    (XLEN)
    ) u_bht (
        .clk       (clk),
        .rst       (rst),
        .rd_pc     (if_pc),
        .rd_ctr    (rd_ctr),
        .upd_en    (bht_upd),
        .upd_pc    (ex_pc),
        .upd_taken (taken)
    );

    assign if_pred_taken  = rd_ctr[1];
    assign unused_ctr_lsb = rd_ctr[0];

    // Redirect in flight means the EX instruction is wrong-path and is dropped
    assign accept = ex_valid & ~ex_stall & ~redirect_valid & (ex_branch | ex_jump);

    // Branch condition evaluation; reserved funct3 codes resolve not-taken
    always_comb begin
        cond_taken = 1'b0;
        f3_valid   = 1'b1;
        case (ex_funct3)
            F3_BEQ:  cond_taken = (ex_rs1 == ex_rs2);
            F3_BNE:  cond_taken = (ex_rs1 != ex_rs2);
            F3_BLT:  cond_taken = ($signed(ex_rs1) <  $signed(ex_rs2));
            F3_BGE:  cond_taken = ($signed(ex_rs1) >= $signed(ex_rs2));
            F3_BLTU: cond_taken = (ex_rs1 <  ex_rs2);
            F3_BGEU: cond_taken = (ex_rs1 >= ex_rs2);
            default: f3_valid   = 1'b0;
        endcase
    end

    assign taken      = ex_jump | cond_taken;
    assign mispredict = accept & (taken != ex_pred_taken);
    assign bht_upd    = accept & ex_branch & ~ex_jump & f3_valid;

    // Registered redirect pulse and resolved outcome
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            resolved_taken <= 1'b0;
        end else begin
            redirect_valid <= mispredict;
            if (accept) begin
                redirect_pc    <= taken ? ex_target : ex_pc + XLEN'(4);
                resolved_taken <= taken;
            end
        end
    end

    // Saturating mispredict performance counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mispredict_cnt <= '0;
        end else if (mispredict && (mispredict_cnt != '1)) begin
            mispredict_cnt <= mispredict_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_branch_resolve_bht.sv
// Directed bench for branch_resolve_bht (CNT_W=4 build for counter saturation).
module tb_branch_resolve_bht;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc;
    logic        if_pred_taken;
    logic        ex_valid, ex_stall, ex_branch, ex_jump;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_rs1, ex_rs2, ex_pc, ex_target;
    logic        ex_pred_taken;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        resolved_taken;
    logic [3:0]  mispredict_cnt;

    int n_vec = 0;
    int n_err = 0;
    int mcnt  = 0;

    typedef struct {
        logic        br;
        logic        jp;
        logic [2:0]  f3;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] pc;
        logic [31:0] tgt;
        logic        pred;
        logic        e_redir;
        logic [31:0] e_rpc;
        logic        e_tk;
        logic        e_bht;
    } vec_t;

    vec_t vt [10];

    branch_resolve_bht #(
        .XLEN        (32),
        .BHT_ENTRIES (64),
        .CNT_W       (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .if_pc          (if_pc),
        .if_pred_taken  (if_pred_taken),
        .ex_valid       (ex_valid),
        .ex_stall       (ex_stall),
        .ex_branch      (ex_branch),
        .ex_jump        (ex_jump),
        .ex_funct3      (ex_funct3),
        .ex_rs1         (ex_rs1),
        .ex_rs2         (ex_rs2),
        .ex_pc          (ex_pc),
        .ex_target      (ex_target),
        .ex_pred_taken  (ex_pred_taken),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .resolved_taken (resolved_taken),
        .mispredict_cnt (mispredict_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic br, input logic jp, input logic [2:0] f3,
                         input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [31:0] pc, input logic [31:0] tgt, input logic pred);
        ex_branch     = br;
        ex_jump       = jp;
        ex_funct3     = f3;
        ex_rs1        = rs1;
        ex_rs2        = rs2;
        ex_pc         = pc;
        ex_target     = tgt;
        ex_pred_taken = pred;
    endtask

    task automatic count_mispredict();
        if (mcnt != 15) mcnt++;
    endtask

    initial begin
        //          br  jp  f3      rs1           rs2           pc            tgt           pred redir rpc           tk  bht
        vt[0] = '{1'b1, 1'b0, 3'b000, 32'd5,        32'd5,        32'h0000_0100, 32'h0000_0140, 1'b0, 1'b1, 32'h0000_0140, 1'b1, 1'b1};
        vt[1] = '{1'b1, 1'b0, 3'b100, 32'hFFFF_FFFF, 32'd1,       32'h0000_0204, 32'h0000_0300, 1'b1, 1'b0, 32'h0000_0300, 1'b1, 1'b1};
        vt[2] = '{1'b1, 1'b0, 3'b110, 32'hFFFF_FFFF, 32'd1,       32'h0000_0208, 32'h0000_0300, 1'b1, 1'b1, 32'h0000_020C, 1'b0, 1'b0};
        vt[3] = '{1'b1, 1'b0, 3'b001, 32'd3,        32'd3,        32'h0000_020C, 32'h0000_0400, 1'b0, 1'b0, 32'h0000_0210, 1'b0, 1'b0};
        vt[4] = '{1'b1, 1'b0, 3'b101, 32'd1,        32'hFFFF_FFFF, 32'h0000_0210, 32'h0000_0500, 1'b0, 1'b1, 32'h0000_0500, 1'b1, 1'b1};
        vt[5] = '{1'b1, 1'b0, 3'b111, 32'd1,        32'hFFFF_FFFF, 32'h0000_0214, 32'h0000_0600, 1'b1, 1'b1, 32'h0000_0218, 1'b0, 1'b0};
        vt[6] = '{1'b0, 1'b1, 3'b000, 32'd0,        32'd0,        32'h0000_0218, 32'h0000_0700, 1'b0, 1'b1, 32'h0000_0700, 1'b1, 1'b0};
        vt[7] = '{1'b1, 1'b0, 3'b010, 32'd1,        32'd1,        32'h0000_021C, 32'h0000_0800, 1'b1, 1'b1, 32'h0000_0220, 1'b0, 1'b0};
        vt[8] = '{1'b1, 1'b0, 3'b001, 32'd1,        32'd1,        32'hFFFF_FFFC, 32'h0000_0900, 1'b1, 1'b1, 32'h0000_0000, 1'b0, 1'b0};
        vt[9] = '{1'b1, 1'b1, 3'b000, 32'd1,        32'd2,        32'h0000_0224, 32'h0000_0A00, 1'b1, 1'b0, 32'h0000_0A00, 1'b1, 1'b0};

        rst = 1'b1;
        if_pc = 32'h100;
        ex_valid = 1'b0;
        ex_stall = 1'b0;
        drive(1'b0, 1'b0, 3'b000, '0, '0, '0, '0, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        tick();

        // Reset state
        chk("rst_pred", {31'd0, if_pred_taken}, 32'd0);
        chk("rst_redir", {31'd0, redirect_valid}, 32'd0);
        chk("rst_rpc", redirect_pc, 32'd0);
        chk("rst_tk", {31'd0, resolved_taken}, 32'd0);
        chk("rst_cnt", {28'd0, mispredict_cnt}, 32'd0);

        // Table-driven single-instruction vectors, each followed by an idle cycle
        for (int i = 0; i < 10; i++) begin
            drive(vt[i].br, vt[i].jp, vt[i].f3, vt[i].rs1, vt[i].rs2, vt[i].pc, vt[i].tgt, vt[i].pred);
            if_pc = vt[i].pc;
            ex_valid = 1'b1;
            #1;
            chk($sformatf("v%0d_pre_read", i), {31'd0, if_pred_taken}, 32'd0);
            tick();
            ex_valid = 1'b0;
            if (vt[i].e_redir) count_mispredict();
            chk($sformatf("v%0d_redir", i), {31'd0, redirect_valid}, {31'd0, vt[i].e_redir});
            chk($sformatf("v%0d_rpc", i), redirect_pc, vt[i].e_rpc);
            chk($sformatf("v%0d_tk", i), {31'd0, resolved_taken}, {31'd0, vt[i].e_tk});
            chk($sformatf("v%0d_cnt", i), {28'd0, mispredict_cnt}, mcnt);
            chk($sformatf("v%0d_bht", i), {31'd0, if_pred_taken}, {31'd0, vt[i].e_bht});
            tick();
            chk($sformatf("v%0d_redir_clr", i), {31'd0, redirect_valid}, 32'd0);
            chk($sformatf("v%0d_rpc_hold", i), redirect_pc, vt[i].e_rpc);
        end

        // Saturation: four taken BNE at one PC, then two not-taken
        if_pc = 32'h3F0;
        drive(1'b1, 1'b0, 3'b001, 32'd1, 32'd2, 32'h3F0, 32'h480, 1'b1);
        ex_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("sat_t%0d_pred", k), {31'd0, if_pred_taken}, 32'd1);
            chk($sformatf("sat_t%0d_redir", k), {31'd0, redirect_valid}, 32'd0);
        end
        ex_rs2 = 32'd1;
        tick();
        ex_valid = 1'b0;
        count_mispredict();
        chk("sat_nt1_redir", {31'd0, redirect_valid}, 32'd1);
        chk("sat_nt1_rpc", redirect_pc, 32'h3F4);
        chk("sat_nt1_pred", {31'd0, if_pred_taken}, 32'd1);
        tick();
        ex_pred_taken = 1'b0;
        ex_valid = 1'b1;
        tick();
        ex_valid = 1'b0;
        chk("sat_nt2_redir", {31'd0, redirect_valid}, 32'd0);
        chk("sat_nt2_pred", {31'd0, if_pred_taken}, 32'd0);
        chk("sat_cnt", {28'd0, mispredict_cnt}, mcnt);

        // Branch directly behind a mispredict is wrong-path and dropped
        drive(1'b1, 1'b0, 3'b000, 32'd1, 32'd1, 32'h3E0, 32'h3A0, 1'b0);
        ex_valid = 1'b1;
        tick();
        count_mispredict();
        chk("shadow_first_redir", {31'd0, redirect_valid}, 32'd1);
        chk("shadow_first_rpc", redirect_pc, 32'h3A0);
        drive(1'b1, 1'b0, 3'b001, 32'd1, 32'd2, 32'h3E4, 32'h3C0, 1'b0);
        tick();
        ex_valid = 1'b0;
        if_pc = 32'h3E4;
        #1;
        chk("shadow_redir", {31'd0, redirect_valid}, 32'd0);
        chk("shadow_rpc_hold", redirect_pc, 32'h3A0);
        chk("shadow_cnt", {28'd0, mispredict_cnt}, mcnt);
        chk("shadow_bht", {31'd0, if_pred_taken}, 32'd0);

        // Stalled branch samples nothing
        drive(1'b1, 1'b0, 3'b000, 32'd1, 32'd1, 32'h3E8, 32'h111, 1'b0);
        if_pc = 32'h3E8;
        ex_valid = 1'b1;
        ex_stall = 1'b1;
        tick();
        chk("stall_redir", {31'd0, redirect_valid}, 32'd0);
        chk("stall_rpc_hold", redirect_pc, 32'h3A0);
        chk("stall_tk_hold", {31'd0, resolved_taken}, 32'd1);
        chk("stall_cnt", {28'd0, mispredict_cnt}, mcnt);
        chk("stall_bht", {31'd0, if_pred_taken}, 32'd0);
        ex_stall = 1'b0;
        ex_valid = 1'b0;

        // Async reset discards a pending redirect and reinitialises the table
        drive(1'b1, 1'b0, 3'b000, 32'd1, 32'd1, 32'h100, 32'h140, 1'b0);
        if_pc = 32'h100;
        ex_valid = 1'b1;
        tick();
        ex_valid = 1'b0;
        chk("mid_rst_pre_redir", {31'd0, redirect_valid}, 32'd1);
        #2 rst = 1'b1;
        #1;
        mcnt = 0;
        chk("mid_rst_redir", {31'd0, redirect_valid}, 32'd0);
        chk("mid_rst_rpc", redirect_pc, 32'd0);
        chk("mid_rst_tk", {31'd0, resolved_taken}, 32'd0);
        chk("mid_rst_cnt", {28'd0, mispredict_cnt}, 32'd0);
        chk("mid_rst_bht", {31'd0, if_pred_taken}, 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Counter saturation with mispredicted JALs (BHT untouched)
        drive(1'b0, 1'b1, 3'b000, '0, '0, 32'h100, 32'h200, 1'b0);
        for (int k = 0; k < 18; k++) begin
            ex_valid = 1'b1;
            tick();
            ex_valid = 1'b0;
            count_mispredict();
            if (k == 13 || k == 14 || k == 17)
                chk($sformatf("cnt_sat_k%0d", k), {28'd0, mispredict_cnt}, mcnt);
            tick();
        end
        chk("cnt_sat_final", {28'd0, mispredict_cnt}, 32'hF);
        chk("cnt_sat_rpc", redirect_pc, 32'h200);
        chk("cnt_sat_bht", {31'd0, if_pred_taken}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/branch_resolve_bht.md
Name: branch_resolve_bht

Overview:
- Parametrised branch resolution and prediction unit for the pipelined RV32 core.
- Evaluates conditional branches and jumps in EX and checks the outcome against the IF-stage prediction.
- Issues a registered one-cycle redirect on mispredict.
- Maintains a 2-bit saturating branch history table (BHT) that IF reads combinationally, plus a saturating mispredict performance counter.

Parameters:
- XLEN, 32, data/address width.
- BHT_ENTRIES, 64, number of BHT counters; power of two, minimum 4.
- CNT_W, 16, width of the mispredict counter.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous reset, active high.
- if_pc  in  XLEN  fetch PC for prediction lookup.
- if_pred_taken  out  1  combinational prediction = MSB of BHT[idx(if_pc)].
- ex_valid  in  1  EX holds a real instruction.
- ex_stall  in  1  EX held this cycle; no sampling.
- ex_branch  in  1  conditional branch (opcode 1100011).
- ex_jump  in  1  JAL/JALR.
- ex_funct3  in  3  branch condition select.
- ex_rs1  in  XLEN  operand 1.
- ex_rs2  in  XLEN  operand 2.
- ex_pc  in  XLEN  PC of the EX instruction.
- ex_target  in  XLEN  computed taken target.
- ex_pred_taken  in  1  prediction carried down from IF.
- redirect_valid  out  1  registered one-cycle flush/redirect pulse.
- redirect_pc  out  XLEN  registered correct next PC.
- resolved_taken  out  1  registered actual direction of last resolved instruction.
- mispredict_cnt  out  CNT_W  saturating mispredict count.

Behaviour:
- Reset (async, rst=1): redirect_valid=0, redirect_pc=0, resolved_taken=0, mispredict_cnt=0, every BHT entry=2'b01 (weakly not-taken).
- idx(pc) = pc[log2(BHT_ENTRIES)+1:2].
- Accept: accept = ex_valid & ~ex_stall & ~redirect_valid & (ex_branch | ex_jump). The ~redirect_valid term drops the wrong-path instruction in the cycle after a redirect.
- Condition, funct3:
  - 000 eq; 001 ne.
  - 100 signed lt; 101 signed ge.
  - 110 unsigned lt; 111 unsigned ge.
  - 010/011: not taken, BHT not updated.
- Actual taken: jump=1 always taken and overrides ex_branch; else the condition result.
- Mispredict = accept & (taken != ex_pred_taken).
- Next clock edge after accept:
  - redirect_valid = mispredict.
  - redirect_pc = taken ? ex_target : ex_pc+4 (XLEN wrap).
  - resolved_taken = taken.
- Cycles with no accept: redirect_valid=0; redirect_pc and resolved_taken hold.
- Latency: EX inputs to redirect outputs = 1 cycle. if_pred_taken has 0 latency.
- BHT update:
  - Only on accept & ex_branch & ~ex_jump & valid funct3.
  - Taken: increment, saturate at 11. Not taken: decrement, saturate at 00.
  - Write lands at the clock edge.
- Same-cycle read/write of one index: if_pred_taken returns the pre-update value.
- mispredict_cnt += 1 on each mispredict; saturates at all-ones, no wrap.
- ex_stall=1: nothing sampled, BHT and counter unchanged, redirect_valid=0 next cycle.
- Reset mid-operation: a pending redirect is discarded; the table reinitialises immediately.

Decomposition:
- Package branch_pkg:
  - funct3 localparams (BEQ..BGEU).
  - typedef logic [1:0] bht_ctr_t.
  - BHT_RESET = 2'b01.
  - Opcode constants for branch/JAL/JALR.
- Sub-module bht_2bit:
  - Parametrised by ENTRIES and XLEN.
  - One combinational read port, one synchronous saturating-update port, async reset.

Test Plan:
- Reset, then if_pc=0x100 -> if_pred_taken=0; all outputs 0; mispredict_cnt=0.
- BEQ rs1=rs2=5, pc=0x100, target=0x140, pred=0 -> next cycle redirect_valid=1, redirect_pc=0x140, resolved_taken=1, mispredict_cnt=1; BHT[idx 0x100]=10; if_pred_taken(0x100)=1.
- BLT signed rs1=0xFFFFFFFF, rs2=1 taken vs BLTU same operands not taken, pred=1 both -> only BLTU redirects, redirect_pc=pc+4.
- Four consecutive taken BNE at one PC -> counter 01→10→11→11 (saturates); one not-taken -> 10; if_pred_taken stays 1.
- Mispredict followed by an ex_valid branch in the next cycle -> second branch ignored (no update, no redirect); ex_stall=1 with a valid branch -> nothing changes.
- JAL with pred=0 -> redirect to ex_target, BHT untouched. funct3=010 -> not taken, no update. Drive 2^CNT_W+2 mispredicts (CNT_W=4 build) -> counter holds 0xF.
